trace_uart: RTL and testbench

- Downstream consumer of the picorv32 trace interface.
- Captures every `trace_valid`/`trace_data` beat into a FIFO and emits each entry as one ASCII hex line on a UART TX pin (8N1).
- Gives a human-readable instruction/data trace on a spare GPIO, next to the existing hello UART.
- Has no backpressure, because the CPU trace port has no ready. Entries that do not fit are dropped and counted.

---
 rtl/trace_uart.sv | 168 ++++++++++++++++
 tb/tb_trace_uart.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_uart.sv
//------------------------------------------------------------------------------
// Module   : trace_uart
// Brief    : Buffers picorv32 trace beats in a FIFO and prints each one as an
//            uppercase hex line (9 digits, CR, LF) on an 8N1 UART TX pin.
//            Optional macro TRACE_UART_OVF_MARK_EN prefixes '!' to the first
//            line started after a dropped beat.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module trace_uart #(
  parameter int BAUD_DIV   = 434,
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_AW    = 4
) (
  input  logic        clk,
  input  logic        resn,
  input  logic        trace_valid,
  input  logic [35:0] trace_data,
  output logic        serialOut,
  output logic        busy,
  output logic [15:0] overflow_count
);

  localparam int               BW        = $clog2(BAUD_DIV);
  localparam logic [BW-1:0]    BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [FIFO_AW:0] FIFO_FULL = (FIFO_AW + 1)'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]         state, state_nxt;
  logic [35:0]        mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;
  logic [BW-1:0]      baud_cnt;
  logic [2:0]         bit_idx;
  logic [3:0]         char_idx;
  logic [35:0]        line;
  logic               line_mark;
  logic [3:0]         pos;
  logic [3:0]         last_idx;
  logic [7:0]         cur_char;
  logic               tx_d;
  logic               tick, full, pop, push, drop, char_done, line_done;

  assign full      = (count == FIFO_FULL);
  assign pop       = (state == S_IDLE) && (count != '0);
  assign push      = trace_valid && !full;
  assign drop      = trace_valid && full;
  assign tick      = (baud_cnt == BAUD_LAST);
  assign char_done = (state == S_STOP) && tick;
  assign last_idx  = line_mark ? 4'd11 : 4'd10;
  assign line_done = char_done && (char_idx == last_idx);
  assign pos       = char_idx - {3'b000, line_mark};
  assign busy      = (state != S_IDLE) || (count != '0);

`ifdef TRACE_UART_OVF_MARK_EN
  logic drop_flag;

  // A drop on the same edge as the pop re-arms the flag for the following line.
  always_ff @(posedge clk) begin
    if (!resn) begin
      drop_flag <= 1'b0;
      line_mark <= 1'b0;
    end else begin
      if (drop)
        drop_flag <= 1'b1;
      else if (pop)
        drop_flag <= 1'b0;
      if (pop)
        line_mark <= drop_flag;
    end
  end
`else
  assign line_mark = 1'b0;
`endif

  // The line register shifts left after each hex digit, so the next digit is always [35:32].
  always_comb begin
    cur_char = 8'h21;
    if (pos < 4'd9)
      cur_char = (line[35:32] < 4'd10) ? {4'h3, line[35:32]} : (8'h37 + {4'h0, line[35:32]});
    else if (pos == 4'd9)
      cur_char = 8'h0D;
    else if (pos == 4'd10)
      cur_char = 8'h0A;
  end

  always_ff @(posedge clk) begin
    if (!resn)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (count != '0) state_nxt = S_START;
      S_START: if (tick) state_nxt = S_DATA;
      S_DATA:  if (tick && (bit_idx == 3'd7)) state_nxt = S_STOP;
      default: if (tick) state_nxt = line_done ? S_IDLE : S_START;
    endcase
  end

  // Next value of the registered TX pin, derived from the state being entered.
  always_comb begin
    tx_d = serialOut;
    case (state_nxt)
      S_START: tx_d = 1'b0;
      S_DATA: begin
        if (state == S_START)
          tx_d = cur_char[0];
        else if (tick)
          tx_d = cur_char[bit_idx + 3'd1];
      end
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resn) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      baud_cnt       <= '0;
      bit_idx        <= '0;
      char_idx       <= '0;
      line           <= '0;
      serialOut      <= 1'b1;
      overflow_count <= '0;
    end else begin
      serialOut <= tx_d;
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
      if (drop && (overflow_count != 16'hFFFF))
        overflow_count <= overflow_count + 16'd1;
      baud_cnt <= ((state == S_IDLE) || tick) ? '0 : baud_cnt + 1'b1;
      if ((state == S_DATA) && tick)
        bit_idx <= bit_idx + 3'd1;
      if (pop) begin
        line     <= mem[rd_ptr];
        char_idx <= '0;
      end else if (char_done) begin
        char_idx <= char_idx + 4'd1;
        if (pos < 4'd9)
          line <= {line[31:0], 4'h0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= trace_data;
  end

endmodule

`default_nettype wire

// File: tb/tb_trace_uart.sv
//------------------------------------------------------------------------------
// Module   : tb_trace_uart
// Brief    : Scoreboard bench for trace_uart: line-level reference model plus a
//            UART receiver that decodes serialOut and checks every character.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_trace_uart;

  localparam int BD    = 4;
  localparam int DEPTH = 16;
`ifdef TRACE_UART_OVF_MARK_EN
  localparam bit MARK_EN = 1'b1;
`else
  localparam bit MARK_EN = 1'b0;
`endif

  typedef struct {
    logic [7:0] ch;
    int         t;
  } exp_t;

  logic        clk = 1'b0;
  logic        resn = 1'b0;
  logic        trace_valid = 1'b0;
  logic [35:0] trace_data = '0;
  logic        serialOut;
  logic        busy;
  logic [15:0] overflow_count;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          cyc = 0;
  int          free_at = 0;
  int          m_cnt;
  int          m_len;
  logic [35:0] m_d;
  logic [3:0]  nib;
  logic [15:0] m_ovf = '0;
  bit          m_flag = 1'b0;
  logic [35:0] mq[$];
  exp_t        expq[$];
  exp_t        e_mod;

  // Receiver state
  bit          chk_en = 1'b0;
  bit          rx_act = 1'b0;
  logic        prev = 1'b1;
  int          rx_start;
  int          off;
  int          bitn;
  logic [7:0]  rx_byte;
  int          lines_rx = 0;
  exp_t        e_mon;

  logic [63:0] rnd;

  trace_uart #(
    .BAUD_DIV  (BD),
    .FIFO_DEPTH(DEPTH),
    .FIFO_AW   (4)
  ) dut (
    .clk           (clk),
    .resn          (resn),
    .trace_valid   (trace_valid),
    .trace_data    (trace_data),
    .serialOut     (serialOut),
    .busy          (busy),
    .overflow_count(overflow_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [35:0] act, input logic [35:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic push_char(input logic [7:0] ch);
    e_mod.ch = ch;
    e_mod.t  = cyc + m_len * 10 * BD;
    expq.push_back(e_mod);
    m_len++;
  endtask

  // Line-level model: a free transmitter pops the head, and each line occupies
  // chars*10*BD clocks followed by one idle clock.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (!resn) begin
        mq.delete();
        expq.delete();
        free_at = 0;
        m_ovf   = '0;
        m_flag  = 1'b0;
      end else begin
        m_cnt = mq.size();
        if ((cyc >= free_at) && (m_cnt > 0)) begin
          m_d   = mq.pop_front();
          m_len = 0;
          if (MARK_EN && m_flag)
            push_char(8'h21);
          for (int i = 8; i >= 0; i--) begin
            nib = m_d[4*i +: 4];
            push_char((nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib}));
          end
          push_char(8'h0D);
          push_char(8'h0A);
          free_at = cyc + m_len * 10 * BD + 1;
          m_flag  = 1'b0;
        end
        if (trace_valid && (m_cnt < DEPTH))
          mq.push_back(trace_data);
        if (trace_valid && (m_cnt >= DEPTH)) begin
          if (m_ovf != 16'hFFFF)
            m_ovf = m_ovf + 16'd1;
          m_flag = 1'b1;
        end
      end
    end
  end

  // UART receiver / scoreboard consumer
  initial begin
    forever begin
      @(negedge clk);
      if (!resn) begin
        rx_act = 1'b0;
        prev   = 1'b1;
      end else if (!rx_act) begin
        if ((prev === 1'b1) && (serialOut === 1'b0)) begin
          rx_act   = 1'b1;
          rx_start = cyc;
        end
        prev = serialOut;
      end else begin
        off = cyc - rx_start;
        if ((off % BD) == (BD / 2)) begin
          bitn = off / BD;
          if ((bitn >= 1) && (bitn <= 8)) begin
            rx_byte[bitn-1] = serialOut;
          end else if (bitn == 9) begin
            rx_act = 1'b0;
            prev   = serialOut;
            if (expq.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL uart_unexpected: got char %02h at cycle %0d, required no output", rx_byte, rx_start);
            end else begin
              e_mon = expq.pop_front();
              checks++;
              if ((rx_byte !== e_mon.ch) || (serialOut !== 1'b1)) begin
                errors++;
                $display("FAIL uart_char: actual %02h stop=%b required %02h stop=1", rx_byte, serialOut, e_mon.ch);
              end
              checks++;
              if (rx_start != e_mon.t) begin
                errors++;
                $display("FAIL uart_timing: start bit at cycle %0d required %0d", rx_start, e_mon.t);
              end
            end
            if (rx_byte == 8'h0A)
              lines_rx++;
          end
        end
      end
    end
  end

  // Every-cycle status comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("busy_cycle", busy, ((cyc + 1 < free_at) || (mq.size() != 0)) ? 36'd1 : 36'd0);
        check("ovf_cycle", overflow_count, m_ovf);
      end
    end
  end

  task automatic drain(input int maxc, input string name);
    int n;
    n = 0;
    while (((mq.size() != 0) || (cyc + 1 < free_at) || rx_act) && (n < maxc)) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (n >= maxc) begin
      errors++;
      $display("FAIL %s_timeout: still busy after %0d cycles, required idle", name, n);
    end
    check({name, "_pending"}, 36'(expq.size()), 36'd0);
    check({name, "_busy"}, busy, 36'd0);
  endtask

  task automatic rand_data();
    rnd = {$urandom, $urandom};
    trace_data = rnd[35:0];
  endtask

  initial begin
    #990000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with a beat presented
    resn = 1'b0;
    trace_valid = 1'b1;
    trace_data = 36'h5_A5A5_A5A5;
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("reset_serial", serialOut, 36'd1);
    check("reset_busy", busy, 36'd0);
    check("reset_ovf", overflow_count, 36'd0);
    resn = 1'b1;
    trace_valid = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    check("post_reset_busy", busy, 36'd0);
    check("post_reset_lines", 36'(lines_rx), 36'd0);

    // Single beat latency and decode
    trace_valid = 1'b1;
    trace_data = 36'h1_2345_ABCD;
    @(posedge clk);
    #1;
    trace_valid = 1'b0;
    check("single_idle_after_capture", serialOut, 36'd1);
    @(posedge clk);
    #1;
    check("single_start_low", serialOut, 36'd0);
    drain(2000, "single");

    // Back-to-back burst into an idle block
    lines_rx = 0;
    for (int i = 0; i < 20; i++) begin
      trace_valid = 1'b1;
      trace_data = 36'(i);
      @(posedge clk);
      #1;
    end
    trace_valid = 1'b0;
    check("burst_ovf", overflow_count, 36'd3);
    drain(20000, "burst");
    check("burst_lines", 36'(lines_rx), 36'd17);

    // Random sparse traffic with occasional overflow
    repeat (4000) begin
      trace_valid = ($urandom_range(0, 39) == 0);
      rand_data();
      @(posedge clk);
      #1;
    end
    trace_valid = 1'b0;
    drain(20000, "random");

    // Reset during data bit 3 of char 2
    lines_rx = 0;
    trace_valid = 1'b1;
    trace_data = 36'h0_DEAD_BEEF;
    @(posedge clk);
    #1;
    trace_valid = 1'b0;
    repeat (2 + 24 * BD) @(posedge clk);
    #1;
    resn = 1'b0;
    @(posedge clk);
    #1;
    check("midchar_serial", serialOut, 36'd1);
    check("midchar_busy", busy, 36'd0);
    check("midchar_ovf", overflow_count, 36'd0);
    resn = 1'b1;
    repeat (600) @(posedge clk);
    #1;
    check("midchar_quiet_busy", busy, 36'd0);
    check("midchar_lines", 36'(lines_rx), 36'd0);

    // Overflow counter saturation
    trace_valid = 1'b1;
    repeat (65800) begin
      rand_data();
      @(posedge clk);
      #1;
    end
    check("sat_ovf", overflow_count, 36'hFFFF);
    repeat (5) @(posedge clk);
    #1;
    check("sat_hold", overflow_count, 36'hFFFF);
    trace_valid = 1'b0;
    resn = 1'b0;
    @(posedge clk);
    #1;
    check("sat_reset_ovf", overflow_count, 36'd0);
    check("sat_reset_serial", serialOut, 36'd1);
    resn = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    check("final_pending", 36'(expq.size()), 36'd0);
    check("final_busy", busy, 36'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
